// File: rtl/muldiv_ctrl.sv
// Iterative multiply/divide sequencer with HI/LO registers for MULT/MULTU/DIV/DIVU.
// Shift-add multiplier and restoring divider on magnitudes, signs fixed up in FIX.
module muldiv_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] Read_data_1,
  input  logic [WIDTH-1:0] Read_data_2,
  input  logic             Mthi,
  input  logic             Mtlo,
  input  logic             Flush,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               neg_q_q, neg_q_d;   // product / quotient negate
  logic               neg_r_q, neg_r_d;   // remainder negate
  logic               div0_q, div0_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   hacc_q, hacc_d;
  logic [WIDTH-1:0]   lacc_q, lacc_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               op_signed, accept;
  logic [WIDTH:0]     mul_sum, div_sh, div_tr;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   res_hi, res_lo;

  always_comb begin
    op_signed = ~Op[0];
    mag_a     = (op_signed && Read_data_1[WIDTH-1]) ? -Read_data_1 : Read_data_1;
    mag_b     = (op_signed && Read_data_2[WIDTH-1]) ? -Read_data_2 : Read_data_2;

    mul_sum = {1'b0, hacc_q} + (lacc_q[0] ? {1'b0, a_q} : '0);
    div_sh  = {hacc_q, lacc_q[WIDTH-1]};
    div_tr  = div_sh - {1'b0, b_q};

    prod     = {hacc_q, lacc_q};
    prod_fix = neg_q_q ? -prod : prod;
    if (div0_q) begin
      res_hi = hacc_q;
      res_lo = '1;
    end else if (is_div_q) begin
      res_hi = neg_r_q ? -hacc_q : hacc_q;
      res_lo = neg_q_q ? -lacc_q : lacc_q;
    end else begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    div0_d   = div0_q;
    a_d      = a_q;
    b_d      = b_q;
    hacc_d   = hacc_q;
    lacc_d   = lacc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    accept   = 1'b0;

    case (state_q)
      IDLE: begin
        if (!Flush) begin
          if (Mthi) hi_d = Read_data_1;
          if (Mtlo) lo_d = Read_data_1;
          accept = Start;
        end
      end
      RUN: begin
        if (Flush) begin
          state_d = IDLE;
        end else begin
          if (!div0_q) begin
            if (is_div_q) begin
              hacc_d = div_tr[WIDTH] ? div_sh[WIDTH-1:0] : div_tr[WIDTH-1:0];
              lacc_d = {lacc_q[WIDTH-2:0], ~div_tr[WIDTH]};
            end else begin
              hacc_d = mul_sum[WIDTH:1];
              lacc_d = {mul_sum[0], lacc_q[WIDTH-1:1]};
            end
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
        end
      end
      FIX: begin
        // Done is already visible this cycle, so the result commits even on Flush.
        state_d = IDLE;
        hi_d    = res_hi;
        lo_d    = res_lo;
        accept  = Start && !Flush;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      state_d  = RUN;
      is_div_d = Op[1];
      neg_q_d  = op_signed && (Read_data_1[WIDTH-1] ^ Read_data_2[WIDTH-1]);
      neg_r_d  = op_signed && Read_data_1[WIDTH-1];
      div0_d   = Op[1] && (Read_data_2 == '0);
      a_d      = mag_a;
      b_d      = mag_b;
      // Divide by zero skips the iterations: one idle RUN cycle, then FIX.
      cnt_d    = div0_d ? CNT_W'(WIDTH - 1) : '0;
      hacc_d   = div0_d ? Read_data_1 : '0;
      lacc_d   = Op[1] ? mag_a : mag_b;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      div0_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      hacc_q   <= '0;
      lacc_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      div0_q   <= div0_d;
      a_q      <= a_d;
      b_q      <= b_d;
      hacc_q   <= hacc_d;
      lacc_q   <= lacc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign Busy = (state_q == RUN);
  assign Done = (state_q == FIX);
  assign HI   = Done ? res_hi : hi_q;
  assign LO   = Done ? res_lo : lo_q;

endmodule
